// File: rtl/alu_op_sequencer.sv
// Request/response sequencer for a combinational ALU: registers operands onto the ALU,
// captures result and flags one cycle later, and keeps an accumulator plus sticky overflow.
module alu_op_sequencer #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned CTRL_W = 3
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              req_valid,
    output logic              req_ready,
    input  logic [CTRL_W-1:0] req_control,
    input  logic [WIDTH-1:0]  req_a,
    input  logic [WIDTH-1:0]  req_b,
    input  logic              req_use_acc,
    input  logic              req_write_acc,

    output logic [WIDTH-1:0]  alu_a,
    output logic [WIDTH-1:0]  alu_b,
    output logic [CTRL_W-1:0] alu_control,
    input  logic [WIDTH-1:0]  alu_out,
    input  logic              alu_overflow,
    input  logic              alu_zero,
    input  logic              alu_negative,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WIDTH-1:0]  rsp_out,
    output logic              rsp_overflow,
    output logic              rsp_zero,
    output logic              rsp_negative,

    output logic [WIDTH-1:0]  acc,
    output logic              sticky_ovf,
    input  logic              clear_sticky
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0] state_q;
    logic [1:0] state_d;
    logic       write_acc_q;
    logic       accept;
    logic       capture;
    logic       sticky_d;

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign accept    = req_valid & req_ready;
    assign capture   = (state_q == EXEC);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A capture with overflow outranks a simultaneous clear.
    always_comb begin
        sticky_d = (clear_sticky ? 1'b0 : sticky_ovf) | (capture & alu_overflow);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            write_acc_q  <= 1'b0;
            alu_a        <= '0;
            alu_b        <= '0;
            alu_control  <= '0;
            rsp_out      <= '0;
            rsp_overflow <= 1'b0;
            rsp_zero     <= 1'b0;
            rsp_negative <= 1'b0;
            acc          <= '0;
            sticky_ovf   <= 1'b0;
        end else begin
            state_q    <= state_d;
            sticky_ovf <= sticky_d;
            if (accept) begin
                alu_a       <= req_use_acc ? acc : req_a;
                alu_b       <= req_b;
                alu_control <= req_control;
                write_acc_q <= req_write_acc;
            end
            if (capture) begin
                rsp_out      <= alu_out;
                rsp_overflow <= alu_overflow;
                rsp_zero     <= alu_zero;
                rsp_negative <= alu_negative;
                if (write_acc_q) begin
                    acc <= alu_out;
                end
            end
        end
    end

    a_state_legal: assert property (@(posedge clock) disable iff (reset) state_q != 2'd3);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: table vectors, multi-cycle corner sequences,
// and randomized ops against an arithmetic reference model with its own ALU.
module tb_alu_op_sequencer;

    logic        clock;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_control;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        req_use_acc;
    logic        req_write_acc;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_control;
    logic [31:0] alu_out;
    logic        alu_overflow;
    logic        alu_zero;
    logic        alu_negative;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_out;
    logic        rsp_overflow;
    logic        rsp_zero;
    logic        rsp_negative;
    logic [31:0] acc;
    logic        sticky_ovf;
    logic        clear_sticky;

    int errors = 0;
    int checks = 0;

    logic [31:0] m_acc;
    logic        m_sticky;

    alu_op_sequencer #(.WIDTH(32), .CTRL_W(3)) dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_control  (req_control),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_use_acc  (req_use_acc),
        .req_write_acc(req_write_acc),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_control  (alu_control),
        .alu_out      (alu_out),
        .alu_overflow (alu_overflow),
        .alu_zero     (alu_zero),
        .alu_negative (alu_negative),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_out      (rsp_out),
        .rsp_overflow (rsp_overflow),
        .rsp_zero     (rsp_zero),
        .rsp_negative (rsp_negative),
        .acc          (acc),
        .sticky_ovf   (sticky_ovf),
        .clear_sticky (clear_sticky)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Returns {overflow, zero, negative, result}; overflow means the wrapped result
    // differs from the exact signed result.
    function automatic logic [34:0] alu_ref(input logic [2:0] c, input logic [31:0] x,
                                            input logic [31:0] y);
        longint      exact;
        logic [31:0] r;
        logic        v;
        exact = 0;
        r     = 0;
        v     = 1'b0;
        case (c)
            3'b010: begin
                exact = longint'($signed(x)) + longint'($signed(y));
                r     = x + y;
                v     = (exact != longint'($signed(r)));
            end
            3'b011: begin
                exact = longint'($signed(x)) - longint'($signed(y));
                r     = x - y;
                v     = (exact != longint'($signed(r)));
            end
            3'b100:  r = x & y;
            3'b101:  r = x | y;
            3'b110:  r = ~(x | y);
            3'b111:  r = x ^ y;
            default: r = 32'd0;
        endcase
        return {v, (r == 32'd0), r[31], r};
    endfunction

    // The attached combinational ALU.
    always_comb begin
        {alu_overflow, alu_zero, alu_negative, alu_out} = alu_ref(alu_control, alu_a, alu_b);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic do_op(input logic [2:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                         input logic ua, input logic wa, input int hold, input logic clr_cap,
                         output logic [31:0] got_out, output logic [2:0] got_flags);
        logic [31:0] a_eff;
        logic [34:0] exp;
        int          n;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        check("req_ready before accept", {31'd0, req_ready}, 32'd1);
        a_eff = ua ? m_acc : a;
        exp   = alu_ref(ctrl, a_eff, b);
        req_control   = ctrl;
        req_a         = a;
        req_b         = b;
        req_use_acc   = ua;
        req_write_acc = wa;
        req_valid     = 1'b1;
        @(negedge clock);
        // Scramble request fields: the sequencer must have latched them already.
        req_valid     = 1'b0;
        req_a         = ~a;
        req_use_acc   = ~ua;
        req_write_acc = ~wa;
        rsp_ready     = 1'b1;
        clear_sticky  = clr_cap;
        check("exec req_ready", {31'd0, req_ready}, 32'd0);
        check("exec rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("exec alu_a", alu_a, a_eff);
        check("exec alu_b", alu_b, b);
        check("exec alu_control", {29'd0, alu_control}, {29'd0, ctrl});
        @(negedge clock);
        clear_sticky = 1'b0;
        rsp_ready    = (hold == 0);
        if (wa) m_acc = exp[31:0];
        m_sticky = (clr_cap ? 1'b0 : m_sticky) | exp[34];
        check("resp rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("resp req_ready", {31'd0, req_ready}, 32'd0);
        check("resp rsp_out", rsp_out, exp[31:0]);
        check("resp flags", {29'd0, rsp_overflow, rsp_zero, rsp_negative}, {29'd0, exp[34:32]});
        check("resp acc", acc, m_acc);
        check("resp sticky_ovf", {31'd0, sticky_ovf}, {31'd0, m_sticky});
        got_out   = rsp_out;
        got_flags = {rsp_overflow, rsp_zero, rsp_negative};
        for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1;
            req_a     = $urandom;
            @(negedge clock);
            check("hold rsp_valid", {31'd0, rsp_valid}, 32'd1);
            check("hold rsp_out", rsp_out, exp[31:0]);
            check("hold req_ready", {31'd0, req_ready}, 32'd0);
            check("hold alu_a", alu_a, a_eff);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clock);
        rsp_ready = 1'b0;
        check("done req_ready", {31'd0, req_ready}, 32'd1);
        check("done rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("done rsp_out held", rsp_out, exp[31:0]);
    endtask

    typedef struct {
        logic [2:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic        ua;
        logic        wa;
        int          hold;
        logic [31:0] out;
        logic [2:0]  flags;   // {overflow, zero, negative}
        logic [31:0] acc;
        logic        sticky;
    } vec_t;

    vec_t tv[10];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] o;
        logic [2:0]  f;
        int          n;

        tv[0] = '{3'b010, 32'd5,         32'd7,         1'b0, 1'b0, 0, 32'h0000000C, 3'b000, 32'd0,         1'b0};
        tv[1] = '{3'b011, 32'd3,         32'd3,         1'b0, 1'b1, 0, 32'h00000000, 3'b010, 32'd0,         1'b0};
        tv[2] = '{3'b010, 32'h123,       32'd9,         1'b1, 1'b1, 0, 32'h00000009, 3'b000, 32'd9,         1'b0};
        tv[3] = '{3'b010, 32'h7FFFFFFF,  32'd1,         1'b0, 1'b0, 5, 32'h80000000, 3'b101, 32'd9,         1'b1};
        tv[4] = '{3'b100, 32'hF0F01234,  32'hFF00FF00,  1'b0, 1'b0, 0, 32'hF0001200, 3'b001, 32'd9,         1'b1};
        tv[5] = '{3'b101, 32'h00FF0000,  32'h0000000F,  1'b0, 1'b0, 1, 32'h00FF000F, 3'b000, 32'd9,         1'b1};
        tv[6] = '{3'b110, 32'h0,         32'h0,         1'b0, 1'b0, 0, 32'hFFFFFFFF, 3'b001, 32'd9,         1'b1};
        tv[7] = '{3'b111, 32'hA5A5A5A5,  32'hA5A5A5A5,  1'b0, 1'b0, 2, 32'h00000000, 3'b010, 32'd9,         1'b1};
        tv[8] = '{3'b011, 32'h0,         32'h0000000A,  1'b1, 1'b1, 0, 32'hFFFFFFFF, 3'b001, 32'hFFFFFFFF,  1'b1};
        tv[9] = '{3'b011, 32'h80000000,  32'd1,         1'b0, 1'b0, 0, 32'h7FFFFFFF, 3'b100, 32'hFFFFFFFF,  1'b1};

        reset         = 1'b1;
        req_valid     = 1'b0;
        req_control   = 3'd0;
        req_a         = 32'd0;
        req_b         = 32'd0;
        req_use_acc   = 1'b0;
        req_write_acc = 1'b0;
        rsp_ready     = 1'b0;
        clear_sticky  = 1'b0;
        m_acc         = 32'd0;
        m_sticky      = 1'b0;
        repeat (3) @(negedge clock);

        check("reset req_ready", {31'd0, req_ready}, 32'd1);
        check("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("reset alu_a", alu_a, 32'd0);
        check("reset alu_b", alu_b, 32'd0);
        check("reset alu_control", {29'd0, alu_control}, 32'd0);
        check("reset rsp_out", rsp_out, 32'd0);
        check("reset rsp flags", {29'd0, rsp_overflow, rsp_zero, rsp_negative}, 32'd0);
        check("reset acc", acc, 32'd0);
        check("reset sticky_ovf", {31'd0, sticky_ovf}, 32'd0);
        reset = 1'b0;
        @(negedge clock);

        for (int i = 0; i < 10; i++) begin
            do_op(tv[i].ctrl, tv[i].a, tv[i].b, tv[i].ua, tv[i].wa, tv[i].hold, 1'b0, o, f);
            check($sformatf("vec%0d out", i), o, tv[i].out);
            check($sformatf("vec%0d flags", i), {29'd0, f}, {29'd0, tv[i].flags});
            check($sformatf("vec%0d acc", i), acc, tv[i].acc);
            check($sformatf("vec%0d sticky", i), {31'd0, sticky_ovf}, {31'd0, tv[i].sticky});
        end

        // Reset while an op is in EXEC drops it and its response.
        req_control   = 3'b010;
        req_a         = 32'd1;
        req_b         = 32'd2;
        req_use_acc   = 1'b0;
        req_write_acc = 1'b1;
        req_valid     = 1'b1;
        @(negedge clock);
        req_valid = 1'b0;
        check("rst-exec in exec", {31'd0, req_ready}, 32'd0);
        reset = 1'b1;
        @(negedge clock);
        reset    = 1'b0;
        m_acc    = 32'd0;
        m_sticky = 1'b0;
        check("rst-exec req_ready", {31'd0, req_ready}, 32'd1);
        check("rst-exec rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst-exec acc", acc, 32'd0);
        check("rst-exec sticky_ovf", {31'd0, sticky_ovf}, 32'd0);
        check("rst-exec rsp_out", rsp_out, 32'd0);
        n = 0;
        repeat (3) begin
            @(negedge clock);
            if (rsp_valid) n++;
        end
        check("rst-exec no late response", n, 32'd0);

        // Clear coinciding with an overflowing capture: capture wins.
        do_op(3'b010, 32'h7FFFFFFF, 32'd1, 1'b0, 1'b0, 0, 1'b1, o, f);
        check("clr+ovf sticky", {31'd0, sticky_ovf}, 32'd1);
        clear_sticky = 1'b1;
        @(negedge clock);
        clear_sticky = 1'b0;
        m_sticky     = 1'b0;
        check("clear alone sticky", {31'd0, sticky_ovf}, 32'd0);

        for (int i = 0; i < 40; i++) begin
            logic [2:0]  c;
            logic [31:0] a;
            logic [31:0] b;
            c = 3'($urandom_range(2, 7));
            a = ($urandom_range(0, 3) == 0) ? 32'h7FFFFFFF : 32'($urandom);
            b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : 32'($urandom);
            do_op(c, a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 3), ($urandom_range(0, 7) == 0), o, f);
            if ($urandom_range(0, 9) == 0) begin
                clear_sticky = 1'b1;
                @(negedge clock);
                clear_sticky = 1'b0;
                m_sticky     = 1'b0;
                check("rand clear sticky", {31'd0, sticky_ovf}, 32'd0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
